// File: rtl/hfrv_mem_arbiter.sv
// hfrv_mem_arbiter: two-master round-robin arbiter in front of one single-port
// synchronous SRAM with 1-cycle read latency. Master 0 is the hf-riscv core port,
// master 1 the debug/loader port. Every access runs ISSUE -> RESP. Read data and an
// ack pulse go to the granted master only.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   mN_req/addr/wdata/be         request + payload; be == 0 means read
//   mN_ack                       one-cycle completion pulse
//   mN_rdata                     mem_rdata while own ack is high, else 0
//   mem_en/addr/wdata/be         registered SRAM command
//   mem_rdata                    SRAM read data, valid the cycle after mem_en
//   busy                         high in ISSUE or RESP
//   stat_*                       saturating grant/conflict counters (optional)
//
// Optional feature: define HFRV_ARB_STATS_EN to add stat_m0_grants, stat_m1_grants
// and stat_conflicts (STAT_W bits each).
module hfrv_mem_arbiter #(
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32,
   parameter int unsigned STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_req,
   input  logic [AW-1:0]     m0_addr,
   input  logic [DW-1:0]     m0_wdata,
   input  logic [DW/8-1:0]   m0_be,
   output logic              m0_ack,
   output logic [DW-1:0]     m0_rdata,
   input  logic              m1_req,
   input  logic [AW-1:0]     m1_addr,
   input  logic [DW-1:0]     m1_wdata,
   input  logic [DW/8-1:0]   m1_be,
   output logic              m1_ack,
   output logic [DW-1:0]     m1_rdata,
   output logic              mem_en,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic [DW/8-1:0]   mem_be,
   input  logic [DW-1:0]     mem_rdata,
   output logic              busy
`ifdef HFRV_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_m0_grants,
   output logic [STAT_W-1:0] stat_m1_grants,
   output logic [STAT_W-1:0] stat_conflicts
`endif
);

   localparam int unsigned BW = DW / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state, nxt_state;
   logic   grant;      // 0 = m0, 1 = m1 (master of the access in flight)
   logic   last;       // most recently served master
   logic   do_grant;   // a new access is captured at this edge
   logic   win;        // master captured when do_grant is high

   logic   mem_en_d, busy_d, m0_ack_d, m1_ack_d;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt_state;
   end

   // Next-state and arbitration. In RESP only the other master is considered,
   // which gives strict alternation under contention.
   always_comb begin
      nxt_state = state;
      do_grant  = 1'b0;
      win       = grant;
      unique case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               do_grant  = 1'b1;
               nxt_state = ISSUE;
               win       = (m0_req && m1_req) ? ~last : m1_req;
            end
         end
         ISSUE: nxt_state = RESP;
         RESP: begin
            if (grant ? m0_req : m1_req) begin
               do_grant  = 1'b1;
               win       = ~grant;
               nxt_state = ISSUE;
            end else begin
               nxt_state = IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Output decode: next values of the registered outputs, plus rdata steering
   always_comb begin
      mem_en_d = (nxt_state == ISSUE);
      busy_d   = (nxt_state != IDLE);
      m0_ack_d = (state == ISSUE) && !grant;
      m1_ack_d = (state == ISSUE) &&  grant;
      m0_rdata = m0_ack ? mem_rdata : '0;
      m1_rdata = m1_ack ? mem_rdata : '0;
   end

   // Output and payload registers; payload is captured only at grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant     <= 1'b0;
         last      <= 1'b1;
         mem_en    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         mem_en <= mem_en_d;
         busy   <= busy_d;
         m0_ack <= m0_ack_d;
         m1_ack <= m1_ack_d;
         if (state == RESP) last <= grant;
         if (do_grant) begin
            grant     <= win;
            mem_addr  <= win ? m1_addr  : m0_addr;
            mem_wdata <= win ? m1_wdata : m0_wdata;
            mem_be    <= win ? m1_be    : m0_be;
         end
      end
   end

`ifdef HFRV_ARB_STATS_EN
   // Saturating statistics counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_m0_grants <= '0;
         stat_m1_grants <= '0;
         stat_conflicts <= '0;
      end else if (do_grant) begin
         if (!win && (stat_m0_grants != '1))
            stat_m0_grants <= stat_m0_grants + STAT_W'(1);
         if (win && (stat_m1_grants != '1))
            stat_m1_grants <= stat_m1_grants + STAT_W'(1);
         if (m0_req && m1_req && (stat_conflicts != '1))
            stat_conflicts <= stat_conflicts + STAT_W'(1);
      end
   end
`else
   logic unused_stat_w;
   assign unused_stat_w = ^STAT_W;
`endif

   logic unused_bw;
   assign unused_bw = ^BW;

endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// tb_hfrv_mem_arbiter: self-checking bench for hfrv_mem_arbiter. A behavioural
// SRAM with 1-cycle read latency sits on the mem_* port. Single-master accesses run
// from a table of hand-computed vectors; contention, reset mid-access, payload
// isolation, early req drop and (with HFRV_ARB_STATS_EN) the counters are run as
// hand-written sequences.
module tb_hfrv_mem_arbiter;

   logic        clk;
   logic        reset_n;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_be, m1_be;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        busy;
`ifdef HFRV_ARB_STATS_EN
   logic [15:0] stat_m0_grants, stat_m1_grants, stat_conflicts;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [0:255];

   hfrv_mem_arbiter #(.AW(32), .DW(32), .STAT_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .busy(busy)
`ifdef HFRV_ARB_STATS_EN
      ,
      .stat_m0_grants(stat_m0_grants), .stat_m1_grants(stat_m1_grants),
      .stat_conflicts(stat_conflicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port SRAM, word indexed by addr[9:2]
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_be == 4'b0000) begin
            mem_rdata <= mem[mem_addr[9:2]];
         end else begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   typedef struct {
      logic        mst;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        chk_rdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_addr = 32'hFFFF_FFFC; m0_wdata = 32'h0; m0_be = 4'h0;
      m1_req = 1'b0; m1_addr = 32'hFFFF_FFFC; m1_wdata = 32'h0; m1_be = 4'h0;
   endtask

   task automatic pulse_reset();
      @(negedge clk); reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;
   endtask

   // One single-master access: request in IDLE, check ISSUE, RESP and return to IDLE
   task automatic run_vec(input vec_t v, input int i);
      @(negedge clk);
      if (!v.mst) begin
         m0_req = 1'b1; m0_addr = v.addr; m0_wdata = v.wdata; m0_be = v.be;
      end else begin
         m1_req = 1'b1; m1_addr = v.addr; m1_wdata = v.wdata; m1_be = v.be;
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_issue_en", i),   32'(mem_en), 32'd1);
      chk($sformatf("v%0d_issue_addr", i), mem_addr, v.addr);
      chk($sformatf("v%0d_issue_be", i),   32'(mem_be), 32'(v.be));
      if (v.be != 4'b0000) chk($sformatf("v%0d_issue_wdata", i), mem_wdata, v.wdata);
      chk($sformatf("v%0d_issue_busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d_issue_acks", i), 32'({m1_ack, m0_ack}), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_resp_acks", i), 32'({m1_ack, m0_ack}), v.mst ? 32'd2 : 32'd1);
      chk($sformatf("v%0d_resp_en", i),   32'(mem_en), 32'd0);
      if (v.chk_rdata)
         chk($sformatf("v%0d_rdata", i), v.mst ? m1_rdata : m0_rdata, v.exp_rdata);
      chk($sformatf("v%0d_other_rdata", i), v.mst ? m0_rdata : m1_rdata, 32'd0);
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_idle_acks", i), 32'({m1_ack, m0_ack}), 32'd0);
   endtask

   task automatic solo_m0_read();
      vec_t v;
      v.mst = 1'b0; v.addr = 32'h100; v.wdata = 32'h0; v.be = 4'h0;
      v.chk_rdata = 1'b1; v.exp_rdata = 32'hDEADBEEF;
      run_vec(v, 99);
   endtask

   initial begin
      int n0, n1;
      logic drop1;

      vecs[0] = '{1'b0, 32'h100, 32'h0,        4'b0000, 1'b1, 32'hDEADBEEF};
      vecs[1] = '{1'b1, 32'h020, 32'h12345678, 4'b0011, 1'b0, 32'h0};
      vecs[2] = '{1'b0, 32'h020, 32'h0,        4'b0000, 1'b1, 32'h00005678};
      vecs[3] = '{1'b1, 32'h100, 32'h0,        4'b0000, 1'b1, 32'hDEADBEEF};
      vecs[4] = '{1'b0, 32'h104, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0};
      vecs[5] = '{1'b1, 32'h104, 32'h0,        4'b0000, 1'b1, 32'hCAFEF00D};
      vecs[6] = '{1'b1, 32'h108, 32'hA5FFFFFF, 4'b1000, 1'b0, 32'h0};
      vecs[7] = '{1'b0, 32'h108, 32'h0,        4'b0000, 1'b1, 32'hA5000000};

      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[32'h100 >> 2] = 32'hDEADBEEF;
      mem[32'h040 >> 2] = 32'h40404040;
      mem[32'h080 >> 2] = 32'h80808080;

      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_acks",   32'({m1_ack, m0_ack}), 32'd0);
      chk("rst_addr",   mem_addr, 32'd0);
      chk("rst_wdata",  mem_wdata, 32'd0);
      chk("rst_be",     32'(mem_be), 32'd0);
      @(negedge clk); reset_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Continuous contention from reset: m0, m1, m0, m1 with acks at t+2/4/6/8
      pulse_reset();
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 32'h100;
      m1_req = 1'b1; m1_addr = 32'h104;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         chk($sformatf("cont%0d_m0_ack", k), 32'(m0_ack), (k % 4 == 2) ? 32'd1 : 32'd0);
         chk($sformatf("cont%0d_m1_ack", k), 32'(m1_ack), (k % 4 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("cont%0d_en", k), 32'(mem_en), (k % 2 == 1) ? 32'd1 : 32'd0);
         if (k % 2 == 1)
            chk($sformatf("cont%0d_addr", k), mem_addr, (k % 4 == 1) ? 32'h100 : 32'h104);
         if (k % 4 == 2) chk($sformatf("cont%0d_m0_rdata", k), m0_rdata, 32'hDEADBEEF);
         if (k % 4 == 0) chk($sformatf("cont%0d_m1_rdata", k), m1_rdata, 32'hCAFEF00D);
      end
      @(negedge clk); idle_inputs();
      @(posedge clk); #1;
      chk("cont_end_busy", 32'(busy), 32'd0);

      // Reset asserted during ISSUE of an m0 read
      @(negedge clk); m0_req = 1'b1; m0_addr = 32'h100;
      @(posedge clk); #1;
      chk("rstmid_issue_en", 32'(mem_en), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rstmid_en",   32'(mem_en), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      m0_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk($sformatf("rstmid_noack%0d", k), 32'(m0_ack), 32'd0);
      end
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk); m0_req = 1'b1; m0_addr = 32'h100; m0_be = 4'h0;
      @(posedge clk); #1;
      chk("rstmid_fresh_en", 32'(mem_en), 32'd1);
      @(posedge clk); #1;
      chk("rstmid_fresh_ack",   32'(m0_ack), 32'd1);
      chk("rstmid_fresh_rdata", m0_rdata, 32'hDEADBEEF);
      @(negedge clk); idle_inputs();
      @(posedge clk);

      // Payload change after grant does not affect the access in flight
      @(negedge clk); m1_req = 1'b1; m1_addr = 32'h40;
      @(posedge clk); #1;
      chk("iso_issue_addr", mem_addr, 32'h40);
      @(negedge clk); m1_addr = 32'h80;
      @(posedge clk); #1;
      chk("iso_resp_addr", mem_addr, 32'h40);
      chk("iso_ack",       32'(m1_ack), 32'd1);
      chk("iso_rdata",     m1_rdata, 32'h40404040);
      @(negedge clk); idle_inputs();
      @(posedge clk);

      // Master drops req during ISSUE: ack still pulses
      @(negedge clk); m0_req = 1'b1; m0_addr = 32'h100;
      @(posedge clk);
      @(negedge clk); m0_req = 1'b0;
      @(posedge clk); #1;
      chk("drop_ack",   32'(m0_ack), 32'd1);
      chk("drop_rdata", m0_rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
      chk("drop_idle_busy", 32'(busy), 32'd0);
      chk("drop_idle_ack",  32'(m0_ack), 32'd0);

`ifdef HFRV_ARB_STATS_EN
      // Three contended grants then two solo m0 grants: order m0,m1,m0,m0,m0
      pulse_reset();
      #1;
      chk("stat_rst_m0", 32'(stat_m0_grants), 32'd0);
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 32'h100;
      m1_req = 1'b1; m1_addr = 32'h104;
      n0 = 0; n1 = 0; drop1 = 1'b0;
      for (int c = 0; c < 40 && n0 < 4; c++) begin
         @(posedge clk); #1;
         if (drop1) begin m1_req = 1'b0; drop1 = 1'b0; end
         if (m1_ack) begin n1++; drop1 = 1'b1; end
         if (m0_ack) begin
            n0++;
            if (n0 == 4) m0_req = 1'b0;
         end
      end
      chk("stat_seq_m0_acks", 32'(n0), 32'd4);
      chk("stat_seq_m1_acks", 32'(n1), 32'd1);
      @(negedge clk); idle_inputs();
      @(posedge clk); #1;
      chk("stat_m0", 32'(stat_m0_grants), 32'd4);
      chk("stat_m1", 32'(stat_m1_grants), 32'd1);
      chk("stat_conf", 32'(stat_conflicts), 32'd3);

      @(negedge clk);
      force dut.stat_m0_grants = 16'hFFFE;
      release dut.stat_m0_grants;
      solo_m0_read();
      chk("stat_sat_reach", 32'(stat_m0_grants), 32'h0000FFFF);
      solo_m0_read();
      chk("stat_sat_hold", 32'(stat_m0_grants), 32'h0000FFFF);
      chk("stat_sat_conf", 32'(stat_conflicts), 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Both acks high together is never legal
   always @(negedge clk) begin
      if (reset_n && m0_ack && m1_ack) begin
         total++;
         bad++;
         $display("FAIL dual_ack: got 11 want not both");
      end
   end

endmodule
